out_port_alloc: RTL and testbench



---
 rtl/out_port_alloc_pkg.sv | 6 +
 rtl/out_port_alloc_if.sv | 26 ++
 rtl/out_port_alloc_rr_pick_one_hot.sv | 26 ++
 rtl/out_port_alloc.sv | 73 +++++++
 tb/tb_out_port_alloc.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/out_port_alloc_pkg.sv
// out_port_alloc_pkg: shared defaults (N_IN, CREDIT_DEPTH) and allocator FSM state encoding
package out_port_alloc_pkg;
  localparam int DEF_N_IN = 4;
  localparam int DEF_CREDIT_DEPTH = 4;
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
endpackage

// File: rtl/out_port_alloc_if.sv
// out_port_alloc_if: request/grant/credit bundle of one output port; master drives req/req_head/req_tail/credit_in, slave drives grant/send/sel_idx/busy/credit_cnt/credit_err
interface out_port_alloc_if import out_port_alloc_pkg::*; #(
  parameter int N_IN = DEF_N_IN,
  parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
  parameter int PTR_W = $clog2(N_IN),
  parameter int CNT_W = $clog2(CREDIT_DEPTH + 1)
);
  logic [N_IN-1:0] req;
  logic [N_IN-1:0] req_head;
  logic [N_IN-1:0] req_tail;
  logic credit_in;
  logic [N_IN-1:0] grant;
  logic send;
  logic [PTR_W-1:0] sel_idx;
  logic busy;
  logic [CNT_W-1:0] credit_cnt;
  logic credit_err;
  modport master (
    output req, req_head, req_tail, credit_in,
    input grant, send, sel_idx, busy, credit_cnt, credit_err
  );
  modport slave (
    input req, req_head, req_tail, credit_in,
    output grant, send, sel_idx, busy, credit_cnt, credit_err
  );
endinterface

// File: rtl/out_port_alloc_rr_pick_one_hot.sv
// rr_pick_one_hot: combinational rotating-priority picker; ports i_in, i_low_pr -> o_grant (one-hot), o_idx; index after i_low_pr is highest priority
module rr_pick_one_hot #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_in,
  input  logic [PW-1:0] i_low_pr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);
  logic w_hit;
  logic [PW-1:0] w_j;
  always_comb begin
    o_idx = '0;
    w_hit = 1'b0;
    w_j = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = PW'((int'(i_low_pr) + k) % N);
      if (!w_hit && i_in[w_j]) begin
        w_hit = 1'b1;
        o_idx = w_j;
      end
    end
    o_grant = w_hit ? N'(1) << o_idx : '0;
  end
endmodule

// File: rtl/out_port_alloc.sv
// out_port_alloc: wormhole output-port allocator with round-robin lock and credit gating; ports clk, reset, bus (out_port_alloc_if.slave); ALLOC_BYPASS_EN re-arbitrates on tail transfer
module out_port_alloc import out_port_alloc_pkg::*; #(
  parameter int N_IN = DEF_N_IN,
  parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH
) (
  input logic clk,
  input logic reset,
  out_port_alloc_if.slave bus
);
  localparam int PTR_W = $clog2(N_IN);
  localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);
  state_t r_state, w_nstate;
  logic [PTR_W-1:0] r_sel, r_low, w_nsel, w_nlow, w_idx;
  logic [CNT_W-1:0] r_cnt;
  logic r_err, w_any, w_tail_xfer, w_full_ret;
  logic [N_IN-1:0] w_elig, w_pick, w_sel_oh;
  assign w_sel_oh = N_IN'(1) << r_sel;
  assign bus.grant = (r_state == ST_LOCKED && bus.req[r_sel] && r_cnt != '0) ? w_sel_oh : '0;
  assign bus.send = |bus.grant;
  assign bus.sel_idx = r_sel;
  assign bus.busy = r_state == ST_LOCKED;
  assign bus.credit_cnt = r_cnt;
  assign bus.credit_err = r_err;
  assign w_tail_xfer = bus.send && bus.req_tail[r_sel];
  assign w_full_ret = bus.credit_in && !bus.send && r_cnt == CNT_W'(CREDIT_DEPTH);
`ifdef ALLOC_BYPASS_EN
  assign w_elig = bus.req & bus.req_head & ~(bus.busy ? w_sel_oh : '0);
`else
  assign w_elig = bus.req & bus.req_head;
`endif
  assign w_any = |w_pick;
  rr_pick_one_hot #(.N(N_IN), .PW(PTR_W)) u_pick (
    .i_in(w_elig),
    .i_low_pr(r_low),
    .o_grant(w_pick),
    .o_idx(w_idx)
  );
  always_comb begin
    w_nstate = r_state;
    w_nsel = r_sel;
    w_nlow = r_low;
    if (r_state == ST_IDLE && w_any) begin
      w_nstate = ST_LOCKED;
      w_nsel = w_idx;
      w_nlow = w_idx;
    end
    if (r_state == ST_LOCKED && w_tail_xfer) begin
`ifdef ALLOC_BYPASS_EN
      w_nstate = w_any ? ST_LOCKED : ST_IDLE;
      w_nsel = w_any ? w_idx : r_sel;
      w_nlow = w_any ? w_idx : r_low;
`else
      w_nstate = ST_IDLE;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel <= '0;
      r_low <= PTR_W'(N_IN - 1);
      r_cnt <= CNT_W'(CREDIT_DEPTH);
      r_err <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_sel <= w_nsel;
      r_low <= w_nlow;
      r_cnt <= (bus.send && !bus.credit_in) ? r_cnt - CNT_W'(1) :
               (bus.credit_in && !bus.send && !w_full_ret) ? r_cnt + CNT_W'(1) : r_cnt;
      r_err <= r_err | w_full_ret;
    end
  end
endmodule

// File: tb/tb_out_port_alloc.sv
// tb_out_port_alloc: directed plus random stimulus checked against a per-cycle behavioural model of the allocator
module tb_out_port_alloc;
  localparam int N = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  bit m_locked;
  int m_owner, m_last, m_cred;
  bit m_err;
  out_port_alloc_if #(.N_IN(N), .CREDIT_DEPTH(DEPTH)) bus ();
  out_port_alloc #(.N_IN(N), .CREDIT_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] e, input int last);
    for (int k = 1; k <= N; k++)
      if (e[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req = '0;
    bus.req_head = '0;
    bus.req_tail = '0;
    bus.credit_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_locked = 0;
    m_owner = 0;
    m_last = N - 1;
    m_cred = DEPTH;
    m_err = 0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_cnt", 32'(bus.credit_cnt), DEPTH);
  endtask
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] h, input logic [N-1:0] t, input logic c);
    int e_grant, w;
    bit snd;
    @(negedge clk);
    bus.req = r;
    bus.req_head = h;
    bus.req_tail = t;
    bus.credit_in = c;
    #1;
    e_grant = (m_locked && r[m_owner] && m_cred > 0) ? (1 << m_owner) : 0;
    snd = e_grant != 0;
    chk("grant", 32'(bus.grant), e_grant);
    chk("send", 32'(bus.send), 32'(snd));
    chk("sel_idx", 32'(bus.sel_idx), m_owner);
    chk("busy", 32'(bus.busy), 32'(m_locked));
    chk("credit_cnt", 32'(bus.credit_cnt), m_cred);
    chk("credit_err", 32'(bus.credit_err), 32'(m_err));
    if (!m_locked) begin
      w = pick(r & h, m_last);
      if (w >= 0) begin
        m_locked = 1;
        m_owner = w;
        m_last = w;
      end
    end else if (snd && t[m_owner]) begin
`ifdef ALLOC_BYPASS_EN
      w = pick(r & h & ~(N'(1) << m_owner), m_owner);
      if (w >= 0) begin
        m_owner = w;
        m_last = w;
      end else m_locked = 0;
`else
      m_locked = 0;
`endif
    end
    if (snd && !c) m_cred--;
    else if (c && !snd) begin
      if (m_cred == DEPTH) m_err = 1;
      else m_cred++;
    end
  endtask
  initial begin
    bus.req = '0;
    bus.req_head = '0;
    bus.req_tail = '0;
    bus.credit_in = 1'b0;
    do_reset();
    repeat (9) step(4'hF, 4'hF, 4'hF, 1'b0);
    do_reset();
    step(4'b0100, 4'b0100, 4'b0000, 1'b0);
    step(4'b1110, 4'b1110, 4'b0000, 1'b0);
    step(4'b1110, 4'b1010, 4'b0000, 1'b0);
    step(4'b1110, 4'b1010, 4'b0100, 1'b0);
    step(4'b1010, 4'b1010, 4'b0000, 1'b0);
    step(4'b1000, 4'b1000, 4'b1000, 1'b0);
    chk("next_winner", 32'(bus.sel_idx), 3);
    do_reset();
    step(4'b0001, 4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0001, 4'b0000, 1'b0);
    repeat (4) step(4'b0001, 4'b0000, 4'b0000, 1'b0);
    chk("blk_cnt", 32'(bus.credit_cnt), 0);
    chk("blk_busy", 32'(bus.busy), 1);
    chk("blk_grant", 32'(bus.grant), 0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b1);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0);
    chk("one_more_cnt", 32'(bus.credit_cnt), 0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(4'b0001, 4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("same_cycle_cnt", 32'(bus.credit_cnt), 2);
    repeat (3) step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    repeat (3) step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("err_sticky", 32'(bus.credit_err), 1);
    do_reset();
    step(4'b0010, 4'b0010, 4'b0000, 1'b0);
    step(4'b1110, 4'b1110, 4'b0000, 1'b0);
    repeat (3) step(4'b1101, 4'b1101, 4'b0000, 1'b0);
    chk("stall_sel", 32'(bus.sel_idx), 1);
    step(4'b1110, 4'b1100, 4'b0000, 1'b0);
    step(4'b1110, 4'b1100, 4'b0010, 1'b0);
    step(4'hF, 4'hF, 4'h0, 1'b1);
    step(4'hF, 4'hF, 4'h0, 1'b1);
    step(4'hF, 4'h0, 4'h0, 1'b0);
    do_reset();
    step(4'hF, 4'hF, 4'hF, 1'b0);
    step(4'hF, 4'hF, 4'hF, 1'b0);
    chk("post_rst_sel", 32'(bus.sel_idx), 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(59) == 0) do_reset();
      else step(4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(3) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
